// File: rtl/prog_rom_loader.sv
// Program image loader: takes a length-prefixed, XOR-checksummed byte stream and
// writes it word-by-word into program memory, holding the MCU in reset meanwhile.
module prog_rom_loader #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 18,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_waddr,
  output logic [DATA_W-1:0] prog_wdata,
  output logic              mcu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0] E_TIMEOUT = 2'd0;
  localparam logic [1:0] E_LEN     = 2'd1;
  localparam logic [1:0] E_WORD    = 2'd2;
  localparam logic [1:0] E_CSUM    = 2'd3;

  localparam int              TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]   T_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [16:0]     MAX_N  = 17'(2 ** ADDR_W);

  state_t             state_q, state_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [7:0]         len_hi_q;
  logic [ADDR_W-1:0]  last_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [7:0]         csum_q;
  logic [1:0]         b0_q;
  logic [7:0]         b1_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [TW-1:0]      tcnt_q;
  logic [15:0]        len_n;
  logic               accept;
  logic               timed_out;

  assign rx_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_B0) ||
                    (state_q == S_B1) || (state_q == S_B2) || (state_q == S_CSUM);
  assign prog_we    = (state_q == S_WRITE);
  assign busy       = rx_ready || prog_we;
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERROR);
  assign mcu_rst    = busy || err;
  assign err_code   = err ? err_code_q : 2'd0;
  assign prog_waddr = waddr_q;
  assign prog_wdata = wdata_q;

  // A dropped load_en aborts, so a byte presented in that same cycle is not consumed.
  assign accept    = rx_valid && rx_ready && load_en;
  assign len_n     = {len_hi_q, rx_data};
  assign timed_out = (TIMEOUT_CYC != 0) && rx_ready && !accept && (tcnt_q == T_LAST);

  // NOTE: every signal written here gets a default first, otherwise a path that
  // skips the assignment infers a latch.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    if (state_q != S_IDLE && !load_en) begin
      state_d = S_IDLE;
    end else if (timed_out) begin
      state_d    = S_ERROR;
      err_code_d = E_TIMEOUT;
    end else begin
      unique case (state_q)
        S_IDLE:   if (load_en) state_d = S_LEN_HI;
        S_LEN_HI: if (accept) state_d = S_LEN_LO;
        S_LEN_LO: if (accept) begin
          if (len_n == '0 || {1'b0, len_n} > MAX_N) begin
            state_d    = S_ERROR;
            err_code_d = E_LEN;
          end else begin
            state_d = S_B0;
          end
        end
        S_B0: if (accept) begin
          if (rx_data[7:2] != '0) begin
            state_d    = S_ERROR;
            err_code_d = E_WORD;
          end else begin
            state_d = S_B1;
          end
        end
        S_B1:    if (accept) state_d = S_B2;
        S_B2:    if (accept) state_d = S_WRITE;
        S_WRITE: state_d = (idx_q == last_q) ? S_CSUM : S_B0;
        S_CSUM: if (accept) begin
          if (rx_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERROR;
            err_code_d = E_CSUM;
          end
        end
        S_DONE, S_ERROR: state_d = state_q;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi_q <= '0;
      last_q   <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      tcnt_q   <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        idx_q  <= '0;
        csum_q <= '0;
        tcnt_q <= '0;
      end else begin
        if (accept)
          tcnt_q <= '0;
        else if (rx_ready && TIMEOUT_CYC != 0)
          tcnt_q <= tcnt_q + TW'(1);
        if (accept && state_q != S_CSUM)
          csum_q <= csum_q ^ rx_data;
        if (state_q == S_WRITE && idx_q != last_q)
          idx_q <= idx_q + ADDR_W'(1);
      end
      // Write address/data are captured on the B2 byte so they are already stable
      // during the WRITE strobe and then hold until the next word completes.
      if (accept) begin
        unique case (state_q)
          S_LEN_HI: len_hi_q <= rx_data;
          S_LEN_LO: last_q   <= ADDR_W'(len_n - 16'd1);
          S_B0:     b0_q     <= rx_data[1:0];
          S_B1:     b1_q     <= rx_data;
          S_B2: begin
            waddr_q <= idx_q;
            wdata_q <= {b0_q, b1_q, rx_data};
          end
          default: ;
        endcase
      end
    end
  end

endmodule
